// File: rtl/sccb_slave_regfile.sv
// -----------------------------------------------------------------------------
// sccb_slave_regfile
//
// SCCB/I2C slave that stands in for the OV5640 camera during emulation and
// bring-up. It accepts register writes (device address byte 0x78, then a
// 16-bit register address, then one or more data bytes) and serves reads
// (device address byte 0x79) from a 256-byte shadow store. Every accepted
// data byte is reported as a one-cycle wr_valid event.
//
// SCL and SDA are treated as plain inputs and oversampled on clk_25M. They
// are never used as clocks.
//
// Parameters:
//   DEV_ADDR     7-bit slave address (0x3C -> 0x78 write / 0x79 read)
//   SYNC_STAGES  synchronizer depth on SCL/SDA ahead of edge detection
//
// Ports:
//   clk_25M      in   system clock that oversamples the bus
//   camera_rstn  in   asynchronous active-low reset
//   scl          in   bus clock from the master
//   sda_in       in   bus data as seen on the pad (wired-AND of all drivers)
//   sda_oe       out  1 = pull SDA low, 0 = release (open-drain)
//   wr_valid     out  one-cycle strobe per accepted data byte
//   wr_addr      out  register address of the reported byte
//   wr_data      out  reported data byte
//   busy         out  high from an addressed START until STOP/abort
//   nack_seen    out  one-cycle strobe when the master NACKs a read byte
// -----------------------------------------------------------------------------
module sccb_slave_regfile #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_25M,
  input  logic        camera_rstn,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        nack_seen
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_AHI,
    ST_ACK_AHI,
    ST_ALO,
    ST_ACK_ALO,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  // Synchronizers and history flops
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;

  // Protocol state
  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  sh_q, sh_d;
  logic [6:0]  rd_sh_q, rd_sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_done_q, byte_done_d;
  logic        rw_q, rw_d;

  // Registered outputs
  logic        sda_oe_q, sda_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        nack_seen_q, nack_seen_d;

  // Shadow store (not reset)
  logic [7:0]  mem [256];
  logic [7:0]  mem_rd;
  logic        mem_we;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign sda_rise = sda_s & ~sda_hist_q;
  assign sda_fall = ~sda_s & sda_hist_q;

  // SCL must be high on both sides of the SDA edge for a bus condition
  assign start_det = sda_fall & scl_s & scl_hist_q;
  assign stop_det  = sda_rise & scl_s & scl_hist_q;

  assign mem_rd = mem[ptr_q[7:0]];

  assign sda_oe    = sda_oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign nack_seen = nack_seen_q;

  always_comb begin
    scl_sync_d[0] = scl;
    sda_sync_d[0] = sda_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      scl_sync_d[i] = scl_sync_q[i-1];
      sda_sync_d[i] = sda_sync_q[i-1];
    end
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Next-state logic. Bits are sampled on SCL rise; everything that touches
  // sda_oe happens on SCL fall. A received byte is flagged by byte_done on its
  // 8th rise and acted upon at the following fall, which is exactly when the
  // ACK must start being driven. In RACK the same flag remembers that the
  // master acknowledged, so the next read byte is loaded at the following fall.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sh_d        = sh_q;
    rd_sh_d     = rd_sh_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    nack_seen_d = 1'b0;
    mem_we      = 1'b0;

    if (start_det) begin
      // busy is left alone here; the address byte decides whether it stays
      state_d     = ST_DEV;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_AHI, ST_ALO, ST_WDATA: begin
          if (scl_rise) begin
            sh_d        = {sh_q[6:0], sda_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            case (state_q)
              ST_DEV: begin
                if (sh_q[7:1] == DEV_ADDR) begin
                  rw_d     = sh_q[0];
                  state_d  = ST_ACK_DEV;
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end
              ST_AHI: begin
                ptr_d[15:8] = sh_q;
                state_d     = ST_ACK_AHI;
                sda_oe_d    = 1'b1;
              end
              ST_ALO: begin
                ptr_d[7:0] = sh_q;
                state_d    = ST_ACK_ALO;
                sda_oe_d   = 1'b1;
              end
              ST_WDATA: begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = sh_q;
                ptr_d      = ptr_q + 16'd1;
                state_d    = ST_ACK_W;
                sda_oe_d   = 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_ACK_DEV: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              // First read bit goes out on the fall that ends the ACK slot
              state_d  = ST_RDATA;
              sda_oe_d = ~mem_rd[7];
              rd_sh_d  = mem_rd[6:0];
            end else begin
              state_d  = ST_AHI;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_ACK_AHI: begin
          if (scl_fall) begin
            state_d  = ST_ALO;
            sda_oe_d = 1'b0;
          end
        end

        ST_ACK_ALO, ST_ACK_W: begin
          if (scl_fall) begin
            state_d  = ST_WDATA;
            sda_oe_d = 1'b0;
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              state_d     = ST_RACK;
              sda_oe_d    = 1'b0;
            end else begin
              sda_oe_d = ~rd_sh_q[6];
              rd_sh_d  = {rd_sh_q[5:0], 1'b0};
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              nack_seen_d = 1'b1;
              state_d     = ST_IGNORE;
            end else begin
              ptr_d       = ptr_q + 16'd1;
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            state_d     = ST_RDATA;
            sda_oe_d    = ~mem_rd[7];
            rd_sh_d     = mem_rd[6:0];
          end
        end

        default: ;
      endcase
    end
  end

  // All control and output flops
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      // Idle bus level, so reset release never looks like an edge
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= ST_IDLE;
      ptr_q       <= 16'h0000;
      sh_q        <= 8'h00;
      rd_sh_q     <= 7'h00;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 16'h0000;
      wr_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      nack_seen_q <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_hist_q  <= scl_hist_d;
      sda_hist_q  <= sda_hist_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sh_q        <= sh_d;
      rd_sh_q     <= rd_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      nack_seen_q <= nack_seen_d;
    end
  end

  // Only the low pointer byte indexes the store; upper byte aliases
  always_ff @(posedge clk_25M) begin
    if (mem_we) begin
      mem[ptr_q[7:0]] <= sh_q;
    end
  end

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_sccb_slave_regfile
//
// Drives SCCB master transactions into sccb_slave_regfile through a wired-AND
// SDA model and checks ACKs, write events, read data and status outputs
// against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sccb_slave_regfile;

  localparam int CLK_HALF = 20;   // 25 MHz
  localparam int Q        = 400;  // quarter SCL period (10 clk_25M cycles)

  logic        clk_25M = 1'b0;
  logic        camera_rstn = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        nack_seen;

  int n_cmp = 0;
  int n_err = 0;

  // Event logs filled by the monitor
  int          wv_cycles = 0;
  int          wv_pulses = 0;
  int          wv_no_oe = 0;
  int          oe_cycles = 0;
  int          busy_cycles = 0;
  int          nack_cycles = 0;
  logic        wv_prev = 1'b0;
  logic [15:0] wv_addr_log[$];
  logic [7:0]  wv_data_log[$];

  assign sda_in = sda_m & ~sda_oe;

  sccb_slave_regfile #(
    .DEV_ADDR    (7'h3C),
    .SYNC_STAGES (2)
  ) dut (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .scl         (scl),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .nack_seen   (nack_seen)
  );

  always #CLK_HALF clk_25M = ~clk_25M;

  // Sample DUT outputs on the inactive clock edge
  always @(negedge clk_25M) begin
    if (wr_valid) begin
      wv_cycles++;
      wv_addr_log.push_back(wr_addr);
      wv_data_log.push_back(wr_data);
      if (!sda_oe) wv_no_oe++;
    end
    if (wr_valid && !wv_prev) wv_pulses++;
    wv_prev = wr_valid;
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
    if (nack_seen) nack_cycles++;
  end

  function automatic logic [15:0] log_addr(input int idx);
    if (idx < wv_addr_log.size()) return wv_addr_log[idx];
    return 16'hxxxx;
  endfunction

  function automatic logic [7:0] log_data(input int idx);
    if (idx < wv_data_log.size()) return wv_data_log[idx];
    return 8'hxx;
  endfunction

  // Bus master primitives
  task automatic bus_start();
    if (scl == 1'b0) begin
      #Q sda_m = 1'b1;
      #Q scl = 1'b1;
    end
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      #Q sda_m = b[i];
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic ack);
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q ack = sda_in;
    #Q scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    ack_slot(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q sda_m = 1'b1;
      #Q scl = 1'b1;
      #Q b = {b[6:0], sda_in};
      #Q scl = 1'b0;
    end
    #Q sda_m = mack;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  // Reset values while camera_rstn is held low
  task automatic test_reset();
    #(10*CLK_HALF);
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wr_valid: got %b want 0", wr_valid); end
    n_cmp++; if (wr_addr !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_wr_addr: got %h want 0000", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_wr_data: got %h want 00", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (nack_seen !== 1'b0) begin n_err++; $display("[TB] FAIL reset_nack_seen: got %b want 0", nack_seen); end
    camera_rstn = 1'b1;
    #(4*Q);
  endtask

  // 0x78 0x31 0x03 0x11 STOP
  task automatic test_single_write();
    logic [3:0] acks;
    int c0, p0, n0;
    c0 = wv_cycles; p0 = wv_pulses; n0 = wv_no_oe;
    bus_start();
    write_byte(8'h78, acks[3]);
    write_byte(8'h31, acks[2]);
    write_byte(8'h03, acks[1]);
    write_byte(8'h11, acks[0]);
    n_cmp++; if (acks !== 4'b0000) begin n_err++; $display("[TB] FAIL single_acks: got %b want 0000", acks); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy_active: got %b want 1", busy); end
    bus_stop();
    #Q;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_busy_after_stop: got %b want 0", busy); end
    n_cmp++; if (wv_cycles - c0 !== 1) begin n_err++; $display("[TB] FAIL single_wv_cycles: got %0d want 1", wv_cycles - c0); end
    n_cmp++; if (wv_pulses - p0 !== 1) begin n_err++; $display("[TB] FAIL single_wv_pulses: got %0d want 1", wv_pulses - p0); end
    n_cmp++; if (wv_no_oe - n0 !== 0) begin n_err++; $display("[TB] FAIL single_wv_with_ack: got %0d want 0", wv_no_oe - n0); end
    n_cmp++; if (log_addr(c0) !== 16'h3103) begin n_err++; $display("[TB] FAIL single_addr: got %h want 3103", log_addr(c0)); end
    n_cmp++; if (log_data(c0) !== 8'h11) begin n_err++; $display("[TB] FAIL single_data: got %h want 11", log_data(c0)); end
  endtask

  // Foreign address: nothing may react
  task automatic test_wrong_addr();
    logic a0, a1;
    int c0, o0, b0;
    c0 = wv_cycles; o0 = oe_cycles; b0 = busy_cycles;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h31, a1);
    write_byte(8'h03, a1);
    write_byte(8'h11, a1);
    bus_stop();
    #Q;
    n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("[TB] FAIL wrong_addr_nack: got %b want 1", a0); end
    n_cmp++; if (oe_cycles - o0 !== 0) begin n_err++; $display("[TB] FAIL wrong_addr_oe: got %0d want 0", oe_cycles - o0); end
    n_cmp++; if (wv_cycles - c0 !== 0) begin n_err++; $display("[TB] FAIL wrong_addr_wv: got %0d want 0", wv_cycles - c0); end
    n_cmp++; if (busy_cycles - b0 !== 0) begin n_err++; $display("[TB] FAIL wrong_addr_busy: got %0d want 0", busy_cycles - b0); end
  endtask

  // Burst write with auto-increment, then a 16-bit pointer wrap
  task automatic test_burst();
    logic [7:0] acks;
    logic [15:0] exp_a [5];
    logic [7:0]  exp_d [5];
    int c0;
    exp_a[0] = 16'h3800; exp_d[0] = 8'hAA;
    exp_a[1] = 16'h3801; exp_d[1] = 8'hBB;
    exp_a[2] = 16'h3802; exp_d[2] = 8'hCC;
    exp_a[3] = 16'hFFFF; exp_d[3] = 8'h12;
    exp_a[4] = 16'h0000; exp_d[4] = 8'h34;
    c0 = wv_cycles;
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'h38, acks[1]);
    write_byte(8'h00, acks[2]);
    write_byte(8'hAA, acks[3]);
    write_byte(8'hBB, acks[4]);
    write_byte(8'hCC, acks[5]);
    bus_stop();
    n_cmp++; if (acks[5:0] !== 6'b000000) begin n_err++; $display("[TB] FAIL burst_acks: got %b want 000000", acks[5:0]); end
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'hFF, acks[1]);
    write_byte(8'hFF, acks[2]);
    write_byte(8'h12, acks[3]);
    write_byte(8'h34, acks[4]);
    bus_stop();
    n_cmp++; if (acks[4:0] !== 5'b00000) begin n_err++; $display("[TB] FAIL wrap_acks: got %b want 00000", acks[4:0]); end
    n_cmp++; if (wv_cycles - c0 !== 5) begin n_err++; $display("[TB] FAIL burst_wv_count: got %0d want 5", wv_cycles - c0); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (log_addr(c0 + k) !== exp_a[k]) begin n_err++; $display("[TB] FAIL burst_addr[%0d]: got %h want %h", k, log_addr(c0 + k), exp_a[k]); end
      n_cmp++; if (log_data(c0 + k) !== exp_d[k]) begin n_err++; $display("[TB] FAIL burst_data[%0d]: got %h want %h", k, log_data(c0 + k), exp_d[k]); end
    end
  endtask

  // Write 0x3817/0x3818, then pointer set + repeated START + two reads
  task automatic test_read_back();
    logic [4:0] acks;
    logic [7:0] rb0, rb1;
    int nk0, c0;
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'h38, acks[1]);
    write_byte(8'h17, acks[2]);
    write_byte(8'hFF, acks[3]);
    write_byte(8'h5A, acks[4]);
    bus_stop();
    n_cmp++; if (acks !== 5'b00000) begin n_err++; $display("[TB] FAIL read_setup_acks: got %b want 00000", acks); end
    nk0 = nack_cycles; c0 = wv_cycles;
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'h38, acks[1]);
    write_byte(8'h17, acks[2]);
    bus_start();
    write_byte(8'h79, acks[3]);
    n_cmp++; if (acks[3:0] !== 4'b0000) begin n_err++; $display("[TB] FAIL read_addr_acks: got %b want 0000", acks[3:0]); end
    read_byte(1'b0, rb0);
    read_byte(1'b1, rb1);
    #Q;
    n_cmp++; if (rb0 !== 8'hFF) begin n_err++; $display("[TB] FAIL read_byte0: got %h want FF", rb0); end
    n_cmp++; if (rb1 !== 8'h5A) begin n_err++; $display("[TB] FAIL read_byte1: got %h want 5A", rb1); end
    n_cmp++; if (nack_cycles - nk0 !== 1) begin n_err++; $display("[TB] FAIL read_nack_pulse: got %0d want 1", nack_cycles - nk0); end
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("[TB] FAIL read_sda_released: got %b want 0", sda_oe); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL read_busy: got %b want 1", busy); end
    bus_stop();
    #Q;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL read_busy_after_stop: got %b want 0", busy); end
    n_cmp++; if (wv_cycles - c0 !== 0) begin n_err++; $display("[TB] FAIL read_no_wv: got %0d want 0", wv_cycles - c0); end
  endtask

  // START after 4 data bits aborts the byte; next transaction is normal
  task automatic test_start_mid_wdata();
    logic [6:0] acks;
    int c0;
    c0 = wv_cycles;
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'h12, acks[1]);
    write_byte(8'h34, acks[2]);
    send_bits(8'h55, 4);
    bus_start();
    n_cmp++; if (wv_cycles - c0 !== 0) begin n_err++; $display("[TB] FAIL abort_no_wv: got %0d want 0", wv_cycles - c0); end
    write_byte(8'h78, acks[3]);
    write_byte(8'h20, acks[4]);
    write_byte(8'h00, acks[5]);
    write_byte(8'h77, acks[6]);
    bus_stop();
    n_cmp++; if (acks !== 7'b0000000) begin n_err++; $display("[TB] FAIL abort_acks: got %b want 0000000", acks); end
    n_cmp++; if (wv_cycles - c0 !== 1) begin n_err++; $display("[TB] FAIL abort_wv_count: got %0d want 1", wv_cycles - c0); end
    n_cmp++; if (log_addr(c0) !== 16'h2000) begin n_err++; $display("[TB] FAIL abort_addr: got %h want 2000", log_addr(c0)); end
    n_cmp++; if (log_data(c0) !== 8'h77) begin n_err++; $display("[TB] FAIL abort_data: got %h want 77", log_data(c0)); end
  endtask

  // Reset asserted while the ACK for the low address byte is being driven
  task automatic test_reset_mid_ack();
    logic [3:0] acks;
    int c0;
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'h50, acks[1]);
    send_bits(8'h01, 8);
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q;
    n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("[TB] FAIL rst_ack_driven: got %b want 1", sda_oe); end
    camera_rstn = 1'b0;
    #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("[TB] FAIL rst_async_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (wr_addr !== 16'h0000) begin n_err++; $display("[TB] FAIL rst_wr_addr: got %h want 0000", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("[TB] FAIL rst_wr_data: got %h want 00", wr_data); end
    n_cmp++; if ({wr_valid, nack_seen} !== 2'b00) begin n_err++; $display("[TB] FAIL rst_strobes: got %b want 00", {wr_valid, nack_seen}); end
    #Q scl = 1'b0;
    #Q scl = 1'b1;
    #Q camera_rstn = 1'b1;
    #(2*Q);
    c0 = wv_cycles;
    bus_start();
    write_byte(8'h78, acks[0]);
    write_byte(8'h50, acks[1]);
    write_byte(8'h01, acks[2]);
    write_byte(8'h99, acks[3]);
    bus_stop();
    n_cmp++; if (acks !== 4'b0000) begin n_err++; $display("[TB] FAIL rst_next_acks: got %b want 0000", acks); end
    n_cmp++; if (wv_cycles - c0 !== 1) begin n_err++; $display("[TB] FAIL rst_next_wv: got %0d want 1", wv_cycles - c0); end
    n_cmp++; if (log_addr(c0) !== 16'h5001) begin n_err++; $display("[TB] FAIL rst_next_addr: got %h want 5001", log_addr(c0)); end
    n_cmp++; if (log_data(c0) !== 8'h99) begin n_err++; $display("[TB] FAIL rst_next_data: got %h want 99", log_data(c0)); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wrong_addr();
    test_burst();
    test_read_back();
    test_start_mid_wdata();
    test_reset_mid_ack();
    #(4*Q);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
